// File: rtl/kernel_ctrl_pkg.sv
// Shared definitions for the kernel load controller: state encoding and kernel sizing helpers.
// The ERR state exists only when KERNEL_LOAD_TIMEOUT_EN is defined.
package kernel_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    LOAD     = 3'd2,
    WAIT_RDY = 3'd3,
    DONE     = 3'd4
`ifdef KERNEL_LOAD_TIMEOUT_EN
    ,
    ERR      = 3'd5
`endif
  } state_e;

  function automatic int kk_of(input int kernel_size);
    return kernel_size * kernel_size;
  endfunction

  // load_count must be able to hold the value KK itself, hence KK+1 codes.
  function automatic int cnt_w_of(input int kernel_size);
    return $clog2(kernel_size * kernel_size + 1);
  endfunction

  localparam int DEFAULT_KERNEL_SIZE = 3;
  localparam int KK    = kk_of(DEFAULT_KERNEL_SIZE);
  localparam int CNT_W = cnt_w_of(DEFAULT_KERNEL_SIZE);

endpackage

// File: rtl/kernel_load_ctrl_if.sv
// Source handshake plus kernel_mem write path of the kernel load controller.
// master = controller side, slave = word source / kernel_mem side.
interface kernel_load_ctrl_if #(
  parameter int BITS = 9
);
  logic            src_valid;
  logic [BITS-1:0] src_data;
  logic            src_ready;
  logic            mem_reset;
  logic            mem_write_en;
  logic [BITS-1:0] mem_kernel_in;
  logic            mem_ready;

  modport master (
    input  src_valid, src_data, mem_ready,
    output src_ready, mem_reset, mem_write_en, mem_kernel_in
  );

  modport slave (
    output src_valid, src_data, mem_ready,
    input  src_ready, mem_reset, mem_write_en, mem_kernel_in
  );
endinterface

// File: rtl/kernel_load_timeout.sv
// Stall counter for the kernel load controller; flags the TIMEOUT_CYCLES-th
// consecutive counted cycle since the last restart.
module kernel_load_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic count_en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = count_en && (cnt_q == W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/kernel_load_ctrl.sv
// Kernel load controller: clears kernel_mem, streams KK words into it, waits for mem_ready.
// Optional stall timeout with ERR state enabled by macro KERNEL_LOAD_TIMEOUT_EN.
module kernel_load_ctrl
  import kernel_ctrl_pkg::*;
#(
  parameter int BITS           = 9,
  parameter int KERNEL_SIZE    = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load_req,
  input  logic                                conv_busy,
  kernel_load_ctrl_if.master                  bus,
  output logic                                kernel_valid,
  output logic                                busy,
  output logic [cnt_w_of(KERNEL_SIZE)-1:0]    load_count,
  output logic                                err
);
  localparam int KK_N  = kk_of(KERNEL_SIZE);
  localparam int CNT_W = cnt_w_of(KERNEL_SIZE);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hs;
  logic               req_ok;

  assign hs     = (state_q == LOAD) && bus.src_valid;
  assign req_ok = load_req && !conv_busy;

`ifdef KERNEL_LOAD_TIMEOUT_EN
  logic timeout;
  logic to_restart;
  logic to_count_en;

  // Stall = LOAD without a handshake, or any WAIT_RDY cycle; state entry restarts.
  assign to_count_en = ((state_q == LOAD) && !hs) || (state_q == WAIT_RDY);
  assign to_restart  = hs || (state_d != state_q);

  kernel_load_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .restart (to_restart),
    .count_en(to_count_en),
    .expired (timeout)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: if (req_ok) state_d = CLEAR;
`ifdef KERNEL_LOAD_TIMEOUT_EN
      ERR:        if (req_ok) state_d = CLEAR;
`endif
      CLEAR: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (hs) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(KK_N - 1)) state_d = WAIT_RDY;
        end
`ifdef KERNEL_LOAD_TIMEOUT_EN
        else if (timeout) state_d = ERR;
`endif
      end
      WAIT_RDY: begin
        if (bus.mem_ready) state_d = DONE;
`ifdef KERNEL_LOAD_TIMEOUT_EN
        else if (timeout) state_d = ERR;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write path is combinational so a word is written in its own handshake cycle.
  always_comb begin
    bus.src_ready     = (state_q == LOAD);
    bus.mem_write_en  = hs;
    bus.mem_kernel_in = (state_q == LOAD) ? bus.src_data : {BITS{1'b0}};
    bus.mem_reset     = reset || (state_q == CLEAR);
    kernel_valid      = (state_q == DONE);
    busy              = (state_q == CLEAR) || (state_q == LOAD) || (state_q == WAIT_RDY);
    load_count        = cnt_q;
`ifdef KERNEL_LOAD_TIMEOUT_EN
    err               = (state_q == ERR);
`else
    err               = 1'b0;
`endif
  end
endmodule

// File: tb/tb_kernel_load_ctrl.sv
// Self-checking bench for kernel_load_ctrl with a shift-register kernel_mem peer.
// Stall scenario depends on KERNEL_LOAD_TIMEOUT_EN.
module tb_kernel_load_ctrl;
  import kernel_ctrl_pkg::*;

  localparam int BITS = 9;
  localparam int KS   = 3;
  localparam int KKN  = kk_of(KS);
  localparam int CW   = cnt_w_of(KS);
  localparam int TO   = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_req;
  logic          conv_busy;
  logic          kernel_valid;
  logic          busy;
  logic [CW-1:0] load_count;
  logic          err;

  kernel_load_ctrl_if #(.BITS(BITS)) bus ();

  kernel_load_ctrl #(
    .BITS(BITS), .KERNEL_SIZE(KS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .conv_busy(conv_busy),
    .bus(bus), .kernel_valid(kernel_valid), .busy(busy),
    .load_count(load_count), .err(err)
  );

  always #5 clk = ~clk;

  // kernel_mem peer: each write shifts toward slot KK-1, new word lands in slot 0.
  logic [BITS-1:0] mem_q [KKN];
  int              mem_cnt = 0;

  always @(posedge clk) begin
    if (bus.mem_reset) begin
      for (int i = 0; i < KKN; i++) mem_q[i] <= '0;
      mem_cnt <= 0;
    end else if (bus.mem_write_en) begin
      for (int i = KKN - 1; i > 0; i--) mem_q[i] <= mem_q[i-1];
      mem_q[0] <= bus.mem_kernel_in;
      if (mem_cnt < KKN) mem_cnt <= mem_cnt + 1;
    end
  end
  assign bus.mem_ready = (mem_cnt == KKN);

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [BITS-1:0] sent_q [$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_req = 1'b0; conv_busy = 1'b0;
    bus.src_valid = 1'b1; bus.src_data = 9'h1A5;
    repeat (3) @(posedge clk);
    #5;
    n_checks++; if (bus.mem_reset !== 1'b1) begin n_fail++; $display("FAIL rst_mem_reset: got %b want 1", bus.mem_reset); end
    n_checks++; if (bus.src_ready !== 1'b0) begin n_fail++; $display("FAIL rst_src_ready: got %b want 0", bus.src_ready); end
    n_checks++; if (bus.mem_write_en !== 1'b0) begin n_fail++; $display("FAIL rst_write_en: got %b want 0", bus.mem_write_en); end
    n_checks++; if (bus.mem_kernel_in !== '0) begin n_fail++; $display("FAIL rst_kernel_in: got %h want 0", bus.mem_kernel_in); end
    n_checks++; if ({kernel_valid, busy, err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got kv/busy/err=%b want 000", {kernel_valid, busy, err}); end
    n_checks++; if (load_count !== '0) begin n_fail++; $display("FAIL rst_load_count: got %0d want 0", load_count); end
    cyc();
    reset = 1'b0; bus.src_valid = 1'b0;
    #4;
    n_checks++; if ({bus.mem_reset, busy, kernel_valid} !== 3'b000) begin n_fail++; $display("FAIL post_rst_idle: got mr/busy/kv=%b want 000", {bus.mem_reset, busy, kernel_valid}); end
    $display("reset: done");
  endtask

  task automatic start_load();
    cyc();
    load_req = 1'b1; conv_busy = 1'b0; bus.src_valid = 1'b0;
    sent_q.delete();
    #4;
    n_checks++; if ({busy, bus.mem_reset} !== 2'b00) begin n_fail++; $display("FAIL pre_clear: got busy/mr=%b want 00", {busy, bus.mem_reset}); end
    cyc();
    load_req = 1'b0;
    #4;
    n_checks++; if (bus.mem_reset !== 1'b1) begin n_fail++; $display("FAIL clear_pulse: got %b want 1", bus.mem_reset); end
    n_checks++; if ({busy, err, kernel_valid, bus.src_ready} !== 4'b1000) begin n_fail++; $display("FAIL clear_flags: got busy/err/kv/rdy=%b want 1000", {busy, err, kernel_valid, bus.src_ready}); end
  endtask

  // mode 0: valid every cycle, data = index+1; mode 1: valid toggles 1,0,...;
  // mode 2: random valid/data with random load_req that must be ignored.
  task automatic feed(input int mode, input int base, input int n, output int cycles);
    int   acc;
    logic v;
    acc    = base;
    cycles = 0;
    while (acc < base + n) begin
      if (cycles >= 200) begin
        n_checks++; n_fail++;
        $display("FAIL feed_budget: got %0d words want %0d", acc, base + n);
        break;
      end
      cyc();
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cycles % 2) == 0) : 1'($urandom_range(0, 1));
      bus.src_valid = v;
      bus.src_data  = (mode == 0) ? BITS'(acc + 1) : BITS'($urandom);
      load_req      = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      #4;
      n_checks++; if ({bus.src_ready, busy, bus.mem_reset} !== 3'b110) begin n_fail++; $display("FAIL load_flags: got rdy/busy/mr=%b want 110", {bus.src_ready, busy, bus.mem_reset}); end
      n_checks++; if (bus.mem_write_en !== v) begin n_fail++; $display("FAIL write_en: got %b want %b", bus.mem_write_en, v); end
      n_checks++; if (load_count !== CW'(acc)) begin n_fail++; $display("FAIL load_count: got %0d want %0d", load_count, acc); end
      if (v) begin
        n_checks++; if (bus.mem_kernel_in !== bus.src_data) begin n_fail++; $display("FAIL kernel_in: got %h want %h", bus.mem_kernel_in, bus.src_data); end
        sent_q.push_back(bus.src_data);
        acc++;
      end
      cycles++;
    end
  endtask

  task automatic finish_load();
    cyc();
    bus.src_valid = 1'b1; load_req = 1'b0;
    #4;
    n_checks++; if ({bus.src_ready, bus.mem_write_en, busy, kernel_valid} !== 4'b0010) begin n_fail++; $display("FAIL wait_rdy_flags: got rdy/we/busy/kv=%b want 0010", {bus.src_ready, bus.mem_write_en, busy, kernel_valid}); end
    n_checks++; if (load_count !== CW'(KKN)) begin n_fail++; $display("FAIL full_count: got %0d want %0d", load_count, KKN); end
    n_checks++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL mem_writes: got %0d want %0d", mem_cnt, KKN); end
    cyc();
    bus.src_valid = 1'b0;
    #4;
    n_checks++; if ({kernel_valid, busy} !== 2'b10) begin n_fail++; $display("FAIL done_flags: got kv/busy=%b want 10", {kernel_valid, busy}); end
    n_checks++; if (sent_q.size() != KKN) begin n_fail++; $display("FAIL sent_words: got %0d want %0d", sent_q.size(), KKN); end
    else begin
      for (int i = 0; i < KKN; i++) begin
        n_checks++; if (mem_q[i] !== sent_q[KKN-1-i]) begin n_fail++; $display("FAIL slot%0d: got %h want %h", i, mem_q[i], sent_q[KKN-1-i]); end
      end
    end
  endtask

  task automatic test_full_load();
    int c;
    start_load();
    feed(0, 0, KKN, c);
    n_checks++; if (c != KKN) begin n_fail++; $display("FAIL full_cycles: got %0d want %0d", c, KKN); end
    finish_load();
    $display("full_load: %0d write cycles", c);
  endtask

  task automatic test_toggle();
    int c;
    start_load();
    feed(1, 0, KKN, c);
    n_checks++; if (c != 2 * KKN - 1) begin n_fail++; $display("FAIL toggle_cycles: got %0d want %0d", c, 2 * KKN - 1); end
    finish_load();
    $display("toggle: %0d cycles", c);
  endtask

  task automatic test_busy_hold();
    int c;
    for (int i = 0; i < 5; i++) begin
      cyc();
      load_req = 1'b1; conv_busy = 1'b1;
      #4;
      n_checks++; if ({kernel_valid, busy, bus.mem_reset} !== 3'b100) begin n_fail++; $display("FAIL pending_hold: got kv/busy/mr=%b want 100", {kernel_valid, busy, bus.mem_reset}); end
    end
    cyc();
    conv_busy = 1'b0;
    #4;
    n_checks++; if (kernel_valid !== 1'b1) begin n_fail++; $display("FAIL release_kv: got %b want 1", kernel_valid); end
    cyc();
    load_req = 1'b0;
    #4;
    n_checks++; if ({kernel_valid, bus.mem_reset, busy} !== 3'b011) begin n_fail++; $display("FAIL reload_clear: got kv/mr/busy=%b want 011", {kernel_valid, bus.mem_reset, busy}); end
    sent_q.delete();
    feed(2, 0, KKN, c);
    finish_load();
    $display("busy_hold: reload in %0d cycles", c);
  endtask

  task automatic test_reset_midload();
    int c;
    start_load();
    feed(0, 0, 4, c);
    cyc();
    reset = 1'b1; bus.src_valid = 1'b1; bus.src_data = 9'h0F0;
    #4;
    n_checks++; if (bus.mem_reset !== 1'b1) begin n_fail++; $display("FAIL mid_rst_mem_reset: got %b want 1", bus.mem_reset); end
    n_checks++; if ({bus.src_ready, bus.mem_write_en, busy, kernel_valid, err} !== 5'b00000) begin n_fail++; $display("FAIL mid_rst_flags: got %b want 00000", {bus.src_ready, bus.mem_write_en, busy, kernel_valid, err}); end
    n_checks++; if ({load_count, bus.mem_kernel_in} !== '0) begin n_fail++; $display("FAIL mid_rst_values: got cnt=%0d data=%h want 0", load_count, bus.mem_kernel_in); end
    cyc();
    reset = 1'b0; bus.src_valid = 1'b0;
    start_load();
    feed(0, 0, KKN, c);
    finish_load();
    $display("reset_midload: reload done");
  endtask

  task automatic test_stall();
    int c;
    start_load();
    feed(0, 0, 3, c);
`ifdef KERNEL_LOAD_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      cyc();
      bus.src_valid = 1'b0;
      #4;
      n_checks++; if ({err, busy} !== 2'b01) begin n_fail++; $display("FAIL stall_%0d: got err/busy=%b want 01", i, {err, busy}); end
    end
    cyc();
    bus.src_valid = 1'b1;
    #4;
    n_checks++; if ({err, busy, bus.src_ready, bus.mem_write_en} !== 4'b1000) begin n_fail++; $display("FAIL timeout_flags: got err/busy/rdy/we=%b want 1000", {err, busy, bus.src_ready, bus.mem_write_en}); end
    start_load();
    feed(0, 0, KKN, c);
    finish_load();
    $display("stall: timeout then reload");
`else
    for (int i = 0; i < 200; i++) begin
      cyc();
      bus.src_valid = 1'b0;
      #4;
      n_checks++; if ({err, busy, bus.src_ready} !== 3'b011) begin n_fail++; $display("FAIL stall_%0d: got err/busy/rdy=%b want 011", i, {err, busy, bus.src_ready}); end
    end
    feed(0, 3, KKN - 3, c);
    finish_load();
    $display("stall: resumed after 200 cycles");
`endif
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_toggle();
    test_busy_hold();
    test_reset_midload();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
